// File: rtl/capseq_pkg.sv
// Shared definitions for the capture sequencer.
//   state_e            : FSM state encoding (3 bits)
//   ARM_CYCLES_DEFAULT : default length of the arm_o pulse, in clock cycles
package capseq_pkg;

  localparam int unsigned ARM_CYCLES_DEFAULT = 4;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StArm      = 3'd1,
    StPrefill  = 3'd2,
    StWaitTrig = 3'd3,
    StCapture  = 3'd4,
    StDone     = 3'd5
  } state_e;

endpackage

// File: rtl/capseq_edge_det.sv
// Rising-edge detector for a level input.
//   i_clk  : clock
//   i_d    : level input
//   o_rise : high for the cycle in which i_d is 1 and was 0 one cycle earlier
module capseq_edge_det (
  input  logic i_clk,
  input  logic i_d,
  output logic o_rise
);

  logic r_d_q;

  // No reset on purpose: the register keeps following the input through reset,
  // so a level that was already high before reset is never reported as a new edge.
  always_ff @(posedge i_clk) begin
    r_d_q <= i_d;
  end

  assign o_rise = i_d & ~r_d_q;

endmodule

// File: rtl/capture_sequencer.sv
// Capture sequencer: arms the FIFO datapath, waits out a prefill period, accepts a
// trigger edge and runs the capture until the datapath asks to stop.
//   adc_sampleclk      : sole clock, rising edge
//   reset_i            : synchronous active-high reset
//   arm_i              : host arm level (rising edge arms, low aborts)
//   trig_i             : trigger level
//   stream_mode        : 1 = stream capture (sampled when arming)
//   presample_i        : prefill cycles before triggers are accepted (sampled when arming)
//   adc_capture_stop   : stop request from the FIFO datapath
//   fifo_overflow      : FIFO overflow flag
//   timeout_i          : WAIT_TRIG timeout in cycles, 0 = off (CAPSEQ_TIMEOUT_EN only)
//   arm_o              : FIFO arm/reset pulse, ARM_CYCLES long
//   adc_capture_go     : capture enable, high while capturing
//   adc_trig_status    : a trigger was accepted since the last arm
//   armed_o            : waiting for prefill or trigger
//   capture_done_o     : capture finished, waiting for arm_i to drop
//   samples_captured_o : capture cycles since arm, saturating
//   overflow_o         : sticky, FIFO overflow during a stream capture
//   timeout_o          : sticky, trigger was forced by the timeout
// Build option: define CAPSEQ_TIMEOUT_EN to add timeout_i and the WAIT_TRIG timeout.
module capture_sequencer
  import capseq_pkg::*;
#(
  parameter int unsigned ARM_CYCLES = ARM_CYCLES_DEFAULT
) (
  input  logic        adc_sampleclk,
  input  logic        reset_i,
  input  logic        arm_i,
  input  logic        trig_i,
  input  logic        stream_mode,
  input  logic [31:0] presample_i,
  input  logic        adc_capture_stop,
  input  logic        fifo_overflow,
`ifdef CAPSEQ_TIMEOUT_EN
  input  logic [31:0] timeout_i,
`endif
  output logic        arm_o,
  output logic        adc_capture_go,
  output logic        adc_trig_status,
  output logic        armed_o,
  output logic        capture_done_o,
  output logic [31:0] samples_captured_o,
  output logic        overflow_o,
  output logic        timeout_o
);

  state_e      r_state;
  state_e      w_state_d;
  logic [7:0]  r_arm_cnt;
  logic [31:0] r_pre_cnt;
  logic        r_stream;
  logic        w_arm_rise;
  logic        w_trig_rise;
  logic        w_timeout_hit;
  logic        w_start;

  capseq_edge_det u_arm_edge (
    .i_clk  (adc_sampleclk),
    .i_d    (arm_i),
    .o_rise (w_arm_rise)
  );

  capseq_edge_det u_trig_edge (
    .i_clk  (adc_sampleclk),
    .i_d    (trig_i),
    .o_rise (w_trig_rise)
  );

`ifdef CAPSEQ_TIMEOUT_EN
  logic [31:0] r_wait_cnt;
  logic        r_timeout;

  // Counts completed WAIT_TRIG cycles; it reads k during the k-th cycle after entry.
  assign w_timeout_hit = (r_state == StWaitTrig) && (timeout_i != 32'd0) &&
                         (r_wait_cnt >= timeout_i - 32'd1);

  always_ff @(posedge adc_sampleclk) begin
    if (reset_i) begin
      r_wait_cnt <= 32'd0;
      r_timeout  <= 1'b0;
    end else begin
      if (r_state != StWaitTrig) begin
        r_wait_cnt <= 32'd0;
      end else if (r_wait_cnt != 32'hFFFF_FFFF) begin
        r_wait_cnt <= r_wait_cnt + 32'd1;
      end
      if (w_start) begin
        r_timeout <= 1'b0;
      end else if (r_state == StWaitTrig && w_state_d == StCapture && !w_trig_rise) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign timeout_o = r_timeout;
`else
  assign w_timeout_hit = 1'b0;
  assign timeout_o     = 1'b0;
`endif

  assign w_start = (r_state == StIdle) && (w_state_d == StArm);

  // Abort (arm_i low) is tested first so it beats trigger, stop and timeout.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:     if (w_arm_rise) w_state_d = StArm;
      StArm:      if (!arm_i) w_state_d = StIdle;
                  else if (r_arm_cnt == 8'd0) w_state_d = StPrefill;
      // Leaving on a count of 1 or 0 gives max(presample, 1) prefill cycles.
      StPrefill:  if (!arm_i) w_state_d = StIdle;
                  else if (r_pre_cnt <= 32'd1) w_state_d = StWaitTrig;
      StWaitTrig: if (!arm_i) w_state_d = StIdle;
                  else if (w_trig_rise || w_timeout_hit) w_state_d = StCapture;
      StCapture:  if (!arm_i) w_state_d = StIdle;
                  else if (adc_capture_stop) w_state_d = StDone;
      StDone:     if (!arm_i) w_state_d = StIdle;
      default:    w_state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state, so they line up with r_state.
  always_ff @(posedge adc_sampleclk) begin
    if (reset_i) begin
      r_state            <= StIdle;
      r_arm_cnt          <= 8'd0;
      r_pre_cnt          <= 32'd0;
      r_stream           <= 1'b0;
      arm_o              <= 1'b0;
      adc_capture_go     <= 1'b0;
      adc_trig_status    <= 1'b0;
      armed_o            <= 1'b0;
      capture_done_o     <= 1'b0;
      samples_captured_o <= 32'd0;
      overflow_o         <= 1'b0;
    end else begin
      r_state        <= w_state_d;
      arm_o          <= (w_state_d == StArm);
      adc_capture_go <= (w_state_d == StCapture);
      armed_o        <= (w_state_d == StPrefill) || (w_state_d == StWaitTrig);
      capture_done_o <= (w_state_d == StDone);
      if (w_start) begin
        r_arm_cnt          <= 8'(ARM_CYCLES - 1);
        r_pre_cnt          <= presample_i;
        r_stream           <= stream_mode;
        adc_trig_status    <= 1'b0;
        samples_captured_o <= 32'd0;
        overflow_o         <= 1'b0;
      end else begin
        if (r_state == StArm && r_arm_cnt != 8'd0) r_arm_cnt <= r_arm_cnt - 8'd1;
        if (r_state == StPrefill && r_pre_cnt != 32'd0) r_pre_cnt <= r_pre_cnt - 32'd1;
        if (r_state == StWaitTrig && w_state_d == StCapture) adc_trig_status <= 1'b1;
        if (r_state == StCapture) begin
          if (samples_captured_o != 32'hFFFF_FFFF) begin
            samples_captured_o <= samples_captured_o + 32'd1;
          end
          if (r_stream && fifo_overflow) overflow_o <= 1'b1;
        end
      end
    end
  end

endmodule
